// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_tx
// Brief    : Parallel-in/serial-out pattern transmitter, MSB first, with
//            back-to-back repeat copies. Optional even-parity bit per copy is
//            compiled in by defining PATTERN_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
  parameter int N        = 6,
  parameter int REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [N-1:0]        i_pattern,
  input  logic                i_start,
  input  logic [REPEAT_W-1:0] i_repeat_cnt,
  output logic                o_serial_out,
  output logic                o_valid_out,
  output logic                o_busy,
  output logic                o_done
);

  localparam int               CNT_W      = $clog2(N);
  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1
`ifdef PATTERN_TX_PARITY_EN
    ,S_PARITY = 2'd2
`endif
  } state_t;

  state_t                r_state;
  logic [N-1:0]          r_pat;
  logic [N-1:0]          r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [REPEAT_W-1:0]   r_copy_cnt;
  logic                  r_serial;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;

  logic [N-1:0]          w_start_pat;
  logic                  w_frame_end;
  logic                  w_last_copy;

  // A simultaneous load+start transmits the new pattern, not the stale one.
  assign w_start_pat = i_load ? i_pattern : r_pat;
  assign w_last_copy = (r_copy_cnt == '0);

`ifdef PATTERN_TX_PARITY_EN
  logic w_parity;
  assign w_parity    = ^r_pat;
  assign w_frame_end = (r_state == S_PARITY);
`else
  assign w_frame_end = (r_state == S_SEND) && (r_bit_cnt == c_LAST_BIT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pat      <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_copy_cnt <= '0;
      r_serial   <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_frame_end) begin
        if (!w_last_copy) begin
          // Reload immediately so the next copy follows with no gap cycle.
          r_copy_cnt <= r_copy_cnt - 1'b1;
          r_shift    <= r_pat << 1;
          r_serial   <= r_pat[N-1];
          r_bit_cnt  <= '0;
          r_state    <= S_SEND;
        end else begin
          r_serial  <= 1'b0;
          r_valid   <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_bit_cnt <= '0;
          r_state   <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_load) begin
              r_pat <= i_pattern;
            end
            if (i_start) begin
              r_copy_cnt <= i_repeat_cnt;
              r_shift    <= w_start_pat << 1;
              r_serial   <= w_start_pat[N-1];
              r_bit_cnt  <= '0;
              r_valid    <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_SEND;
            end
          end
          S_SEND: begin
`ifdef PATTERN_TX_PARITY_EN
            if (r_bit_cnt == c_LAST_BIT) begin
              r_serial <= w_parity;
              r_state  <= S_PARITY;
            end else
`endif
            begin
              r_serial  <= r_shift[N-1];
              r_shift   <= r_shift << 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          default: begin
            r_serial <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_serial_out = r_serial;
  assign o_valid_out  = r_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_tx
// Brief    : Scoreboard bench for serial_pattern_tx (N=6, REPEAT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

  logic       clk;
  logic       rst_n;
  logic       i_load;
  logic [5:0] i_pattern;
  logic       i_start;
  logic [3:0] i_repeat_cnt;
  logic       o_serial_out;
  logic       o_valid_out;
  logic       o_busy;
  logic       o_done;

  serial_pattern_tx #(.N(6), .REPEAT_W(4)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (i_load),
    .i_pattern    (i_pattern),
    .i_start      (i_start),
    .i_repeat_cnt (i_repeat_cnt),
    .o_serial_out (o_serial_out),
    .o_valid_out  (o_valid_out),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic is_done;
    logic b;
  } exp_t;

  exp_t       sb_q[$];
  int         tests_run    = 0;
  int         tests_failed = 0;
  logic       expect_next  = 1'b0;
  logic       det_en       = 1'b0;
  logic [5:0] det_sh       = '0;
  int         det_idx      = 0;
  int         match_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  task automatic push_burst(input logic [5:0] pat, input int reps);
    for (int c = 0; c <= reps; c++) begin
      for (int i = 5; i >= 0; i--) sb_q.push_back('{is_done: 1'b0, b: pat[i]});
`ifdef PATTERN_TX_PARITY_EN
      sb_q.push_back('{is_done: 1'b0, b: ^pat});
`endif
    end
    sb_q.push_back('{is_done: 1'b1, b: 1'b0});
  endtask

  // Monitor: every frame bit or done pulse pops one scoreboard entry.
  always @(negedge clk) begin
    exp_t it;
    if (rst_n) begin
      if (o_valid_out || o_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          it = sb_q.pop_front();
          if (o_valid_out) begin
            check("bit_not_done_slot", o_valid_out, !it.is_done);
            check("serial_bit", o_serial_out, it.b);
            check("busy_during_bit", o_busy, 1'b1);
            check("done_during_bit", o_done, 1'b0);
          end else begin
            check("done_slot", o_done, it.is_done);
            check("busy_in_done", o_busy, 1'b0);
          end
        end
        expect_next = o_valid_out && (sb_q.size() > 0);
        if (o_valid_out && det_en) begin
          det_sh = {det_sh[4:0], o_serial_out};
          det_idx++;
          if (det_idx >= 6 && det_sh == 6'b110010) match_q.push_back(det_idx);
        end
      end else begin
        if (expect_next) check("gap_in_stream", 32'd1, 32'd0);
        expect_next = 1'b0;
        if (o_serial_out) check("idle_serial_zero", o_serial_out, 1'b0);
      end
    end
  end

  task automatic do_load(input logic [5:0] pat);
    i_load = 1'b1; i_pattern = pat;
    @(posedge clk); #1;
    i_load = 1'b0;
  endtask

  task automatic do_start(input logic ld, input logic [5:0] pat, input logic [3:0] reps);
    i_load = ld; i_pattern = pat; i_start = 1'b1; i_repeat_cnt = reps;
    @(posedge clk); #1;
    i_load = 1'b0; i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || o_busy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_timeout"}, (n < 400), 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; i_load = 1'b0; i_pattern = '0; i_start = 1'b0; i_repeat_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_serial", o_serial_out, 1'b0);
    check("rst_valid", o_valid_out, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single copy of 101101.
    do_load(6'b101101);
    push_burst(6'b101101, 0);
    do_start(1'b0, 6'b000000, 4'd0);
    wait_idle("single");

    // Three contiguous copies looped into a detector model.
    det_sh = '0; det_idx = 0; match_q.delete(); det_en = 1'b1;
    do_load(6'b110010);
    push_burst(6'b110010, 2);
    do_start(1'b0, 6'b000000, 4'd2);
    wait_idle("triple");
    det_en = 1'b0;
`ifndef PATTERN_TX_PARITY_EN
    check("match_count", match_q.size(), 3);
    if (match_q.size() == 3) begin
      check("match_pos0", match_q[0], 6);
      check("match_pos1", match_q[1], 12);
      check("match_pos2", match_q[2], 18);
    end
`endif

    // start/load while busy are ignored; register keeps 110010.
    push_burst(6'b110010, 1);
    do_start(1'b0, 6'b000000, 4'd1);
    repeat (3) @(posedge clk);
    #1;
    i_start = 1'b1; i_load = 1'b1; i_pattern = 6'b000111;
    repeat (2) @(posedge clk);
    #1;
    i_start = 1'b0; i_load = 1'b0;
    wait_idle("busy_ignore");
    push_burst(6'b110010, 0);
    do_start(1'b0, 6'b000000, 4'd0);
    wait_idle("after_ignore");

    // Load and start together: new pattern wins.
    push_burst(6'b011000, 0);
    do_start(1'b1, 6'b011000, 4'd0);
    wait_idle("load_start");

    // Start during the done cycle is accepted.
    push_burst(6'b011000, 0);
    push_burst(6'b011000, 0);
    do_start(1'b0, 6'b000000, 4'd0);
    n = 0;
    while (!o_done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", o_done, 1'b1);
    i_start = 1'b1; i_repeat_cnt = 4'd0;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_idle("start_in_done");

    // Maximum repeat count: 16 copies.
    do_load(6'b101101);
    push_burst(6'b101101, 15);
    do_start(1'b0, 6'b000000, 4'hF);
    wait_idle("max_repeat");

    // Reset mid-burst aborts without done, clears the pattern register.
    push_burst(6'b101101, 0);
    do_start(1'b0, 6'b000000, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    expect_next = 1'b0;
    #1;
    check("arst_serial", o_serial_out, 1'b0);
    check("arst_valid", o_valid_out, 1'b0);
    check("arst_busy", o_busy, 1'b0);
    check("arst_done", o_done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("no_done_after_abort", o_done, 1'b0);
    end
    push_burst(6'b000000, 0);
    do_start(1'b0, 6'b111111, 4'd0);
    wait_idle("post_reset_zero");

`ifdef PATTERN_TX_PARITY_EN
    do_load(6'b101100);
    push_burst(6'b101100, 1);
    do_start(1'b0, 6'b000000, 4'd1);
    wait_idle("parity");
`endif

    check("queue_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
